// File: rtl/fft_pkg.sv
// fft_pkg: shared types and constants for the 8-point FFT datapath and its frame sequencer
package fft_pkg;
  localparam int DATA_W = 50;
  localparam int HALF_W = 25;
  localparam int N_PTS  = 8;
  localparam int TW_W   = 18;
  typedef logic [DATA_W-1:0] cplx_t;
  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} seq_state_t;
endpackage

// File: rtl/fft_frame_buf.sv
// fft_frame_buf: 8-entry complex bank with serial write, parallel load, serial and parallel read
module fft_frame_buf
  import fft_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_idx,
  input  cplx_t      wr_data,
  input  logic       ld_en,
  input  cplx_t      ld_data [N_PTS-1:0],
  input  logic [2:0] rd_idx,
  output cplx_t      rd_data,
  output cplx_t      bank [N_PTS-1:0]
);
  // parallel load wins: the sequencer never writes serially while the datapath result is loading
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < N_PTS; i++) bank[i] <= '0;
    else if (ld_en) bank <= ld_data;
    else if (wr_en) bank[wr_idx] <= wr_data;
  assign rd_data = bank[rd_idx];
endmodule

// File: rtl/fft8_stage_sequencer.sv
// fft8_stage_sequencer: LOAD/COMPUTE/UNLOAD frame controller around an external butterfly datapath
module fft8_stage_sequencer
  import fft_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int STAGE_LAT  = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       s_valid_i,
  output logic       s_ready_o,
  input  cplx_t      s_data_i,
  input  logic       s_last_i,
  output logic       m_valid_o,
  input  logic       m_ready_i,
  output cplx_t      m_data_o,
  output logic       m_last_o,
  output cplx_t      bf_data_o [7:0],
  output logic [1:0] bf_stage_o,
  input  cplx_t      bf_data_i [7:0],
  output logic       busy_o,
  output logic       err_o
);
  localparam int CW = STAGE_LAT > 0 ? $clog2(STAGE_LAT + 1) : 1;
  seq_state_t    state, state_d;
  logic [2:0]    wr_idx, rd_idx;
  logic [1:0]    pass;
  logic [CW-1:0] wait_cnt;
  logic          s_hs, m_hs, step, last_pass;
  cplx_t         rd_data;
  assign s_hs      = s_valid_i && s_ready_o;
  assign m_hs      = m_valid_o && m_ready_i;
  assign step      = state == COMPUTE && wait_cnt == CW'(STAGE_LAT);
  assign last_pass = pass == 2'(NUM_STAGES - 1);
  fft_frame_buf u_buf (
    .clk     (clk_i),
    .rst     (rst_i),
    .wr_en   (s_hs),
    .wr_idx  (wr_idx),
    .wr_data (s_data_i),
    .ld_en   (step),
    .ld_data (bf_data_i),
    .rd_idx  (rd_idx),
    .rd_data (rd_data),
    .bank    (bf_data_o)
  );
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= LOAD;
    else state <= state_d;
  always_comb
    state_d = s_hs && wr_idx == 3'd7 ? COMPUTE :
              step && last_pass      ? UNLOAD  :
              m_hs && rd_idx == 3'd7 ? LOAD    : state;
  // an early last restarts the frame; a missing last is flagged but the frame still completes
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wr_idx   <= '0;
      rd_idx   <= '0;
      pass     <= '0;
      wait_cnt <= '0;
      err_o    <= 1'b0;
    end else begin
      err_o <= s_hs && (s_last_i != (wr_idx == 3'd7));
      if (s_hs) wr_idx <= s_last_i ? '0 : wr_idx + 3'd1;
      if (m_hs) rd_idx <= rd_idx + 3'd1;
      if (state == COMPUTE) wait_cnt <= step ? '0 : wait_cnt + CW'(1);
      if (step) pass <= last_pass ? '0 : pass + 2'd1;
    end
  always_comb begin
    s_ready_o  = state == LOAD && !rst_i;
    m_valid_o  = state == UNLOAD;
    m_data_o   = m_valid_o ? rd_data : '0;
    m_last_o   = m_valid_o && rd_idx == 3'd7;
    busy_o     = state != LOAD;
    bf_stage_o = pass;
  end
endmodule

// File: tb/tb_fft8_stage_sequencer.sv
// tb_fft8_stage_sequencer: directed/randomized frames against a per-frame arithmetic reference
module tb_fft8_stage_sequencer;
  import fft_pkg::*;
  logic clk = 0, rst = 1, s_valid = 0, s_last = 0, m_ready = 0, sel = 0;
  bit   mode = 0;
  cplx_t s_data = '0;
  logic s_ready0, s_ready1, m_valid0, m_valid1, m_last0, m_last1, busy0, busy1, err0, err1;
  logic [1:0] st0, st1;
  cplx_t m_data0, m_data1;
  cplx_t bfo0 [7:0], bfi0 [7:0], bfo1 [7:0], bfi1 [7:0];
  logic s_ready, m_valid, m_last, busy, err, any;
  logic [1:0] stage;
  cplx_t m_data;
  cplx_t fr [8], ex [8];
  int checks = 0, failures = 0, err_cnt = 0, e0, n;

  always #5 clk = ~clk;

  // stub butterfly: re += 1 per pass; in mode 1 also re += stage and im += element index
  function automatic cplx_t stub(cplx_t x, int i, logic [1:0] st, bit md);
    logic [HALF_W-1:0] re, im;
    re = x[DATA_W-1:HALF_W] + 25'd1 + (md ? 25'(st) : 25'd0);
    im = x[HALF_W-1:0] + (md ? 25'(i) : 25'd0);
    return {re, im};
  endfunction

  // three passes of the stub collapse to: re += 3 (+0+1+2 in mode 1), im += 3*k in mode 1
  function automatic cplx_t model(cplx_t x, int k, bit md);
    logic [HALF_W-1:0] re, im;
    re = x[DATA_W-1:HALF_W] + 25'(md ? 6 : 3);
    im = x[HALF_W-1:0] + (md ? 25'(3 * k) : 25'd0);
    return {re, im};
  endfunction

  always_comb
    for (int i = 0; i < 8; i++) begin
      bfi0[i] = stub(bfo0[i], i, st0, mode);
      bfi1[i] = stub(bfo1[i], i, st1, mode);
    end

  assign s_ready = sel ? s_ready1 : s_ready0;
  assign m_valid = sel ? m_valid1 : m_valid0;
  assign m_data  = sel ? m_data1  : m_data0;
  assign m_last  = sel ? m_last1  : m_last0;
  assign busy    = sel ? busy1    : busy0;
  assign err     = sel ? err1     : err0;
  assign stage   = sel ? st1      : st0;

  always @(posedge clk) if (err) err_cnt <= err_cnt + 1;

  fft8_stage_sequencer d0 (
    .clk_i(clk), .rst_i(rst), .s_valid_i(s_valid), .s_ready_o(s_ready0), .s_data_i(s_data),
    .s_last_i(s_last), .m_valid_o(m_valid0), .m_ready_i(m_ready), .m_data_o(m_data0),
    .m_last_o(m_last0), .bf_data_o(bfo0), .bf_stage_o(st0), .bf_data_i(bfi0),
    .busy_o(busy0), .err_o(err0)
  );
  fft8_stage_sequencer #(.STAGE_LAT(2)) d1 (
    .clk_i(clk), .rst_i(rst), .s_valid_i(s_valid), .s_ready_o(s_ready1), .s_data_i(s_data),
    .s_last_i(s_last), .m_valid_o(m_valid1), .m_ready_i(m_ready), .m_data_o(m_data1),
    .m_last_o(m_last1), .bf_data_o(bfo1), .bf_stage_o(st1), .bf_data_i(bfi1),
    .busy_o(busy1), .err_o(err1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_checks();
    logic z;
    z = 0;
    for (int i = 0; i < 8; i++) z |= |(sel ? bfo1[i] : bfo0[i]);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_stage", stage, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_bank", z, 0);
  endtask

  task automatic do_reset();
    rst = 1;
    #1 reset_checks();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    #1 chk("ready_after_release", s_ready, 1);
  endtask

  task automatic rand_frame(output cplx_t f [8]);
    for (int k = 0; k < 8; k++) f[k] = {25'($urandom), 25'($urandom)};
  endtask

  task automatic mk_exp(input cplx_t f [8], input bit md, output cplx_t e [8]);
    for (int k = 0; k < 8; k++) e[k] = model(f[k], k, md);
  endtask

  task automatic send_sample(input cplx_t d, input bit last);
    int w = 0;
    s_valid = 1;
    s_data  = d;
    s_last  = last;
    while (!s_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", 64'(w < 100), 1);
    @(negedge clk);
    s_valid = 0;
    s_last  = 0;
  endtask

  task automatic send_frame(input cplx_t f [8], input int cnt, input int last_at, input bit gaps);
    for (int k = 0; k < cnt; k++) begin
      if (gaps && $urandom_range(0, 2) == 0) @(negedge clk);
      send_sample(f[k], k == last_at);
    end
  endtask

  task automatic compute_wait(input int per_stage);
    for (int j = 0; j < 3 * per_stage; j++) begin
      chk("stage", stage, j / per_stage);
      chk("busy_compute", busy, 1);
      chk("valid_in_compute", m_valid, 0);
      @(negedge clk);
    end
    chk("latency_valid", m_valid, 1);
  endtask

  task automatic recv_frame(input cplx_t e [8], input int pat);
    int idx = 0, cyc = 0;
    bit stall = 0;
    cplx_t held = '0;
    while (idx < 8 && cyc < 400) begin
      m_ready = (pat == 0) || (pat == 1 && (cyc % 4 == 0 || cyc % 4 == 3)) ||
                (pat == 2 && $urandom_range(0, 1) == 1);
      if (m_valid) begin
        if (stall) chk("stall_stable", m_data, held);
        chk("input_blocked", s_ready, 0);
        if (m_ready) begin
          chk($sformatf("data%0d", idx), m_data, e[idx]);
          chk($sformatf("last%0d", idx), m_last, idx == 7);
          idx++;
          stall = 0;
        end else begin
          held  = m_data;
          stall = 1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    m_ready = 0;
    chk("frame_complete", idx, 8);
    chk("ready_after_unload", s_ready, 1);
    chk("valid_after_unload", m_valid, 0);
    chk("busy_after_unload", busy, 0);
  endtask

  initial begin
    do_reset();
    // basic frame: re=k, im=0, +1 per pass
    for (int k = 0; k < 8; k++) fr[k] = {25'(k), 25'd0};
    mk_exp(fr, 0, ex);
    chk("basic_exp_model", ex[5], {25'd8, 25'd0});
    send_frame(fr, 8, 7, 0);
    chk("err_basic", err, 0);
    compute_wait(1);
    recv_frame(ex, 0);
    // early last, then a full frame
    mode = 1;
    e0 = err_cnt;
    rand_frame(fr);
    send_frame(fr, 3, 2, 0);
    chk("err_early", err, 1);
    chk("early_stays_load", s_ready, 1);
    rand_frame(fr);
    mk_exp(fr, 1, ex);
    send_frame(fr, 8, 7, 1);
    compute_wait(1);
    recv_frame(ex, 0);
    chk("err_count_early", err_cnt - e0, 1);
    // missing last
    e0 = err_cnt;
    rand_frame(fr);
    mk_exp(fr, 1, ex);
    send_frame(fr, 8, -1, 0);
    chk("err_missing", err, 1);
    compute_wait(1);
    recv_frame(ex, 0);
    chk("err_count_missing", err_cnt - e0, 1);
    // sink backpressure: fixed 1,0,0,1 and random
    rand_frame(fr);
    mk_exp(fr, 1, ex);
    send_frame(fr, 8, 7, 1);
    compute_wait(1);
    recv_frame(ex, 1);
    rand_frame(fr);
    mk_exp(fr, 1, ex);
    send_frame(fr, 8, 7, 1);
    compute_wait(1);
    recv_frame(ex, 2);
    // STAGE_LAT=2 instance
    sel = 1;
    do_reset();
    rand_frame(fr);
    mk_exp(fr, 1, ex);
    send_frame(fr, 8, 7, 0);
    compute_wait(3);
    recv_frame(ex, 2);
    // mid-frame reset during pass 1
    sel = 0;
    do_reset();
    rand_frame(fr);
    send_frame(fr, 8, 7, 0);
    n = 0;
    while (stage != 2'd1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("reach_pass1", stage, 1);
    rst = 1;
    #1 reset_checks();
    @(negedge clk);
    rst = 0;
    #1 chk("ready_after_midreset", s_ready, 1);
    any = 0;
    repeat (12) begin
      @(negedge clk);
      any |= m_valid;
    end
    chk("no_output_after_reset", any, 0);
    rand_frame(fr);
    mk_exp(fr, 1, ex);
    send_frame(fr, 8, 7, 1);
    compute_wait(1);
    recv_frame(ex, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
